// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port Memory between instruction fetch and
//            load/store. One access is issued per cycle; read data returns
//            one cycle later on mem_dout and is steered to the requester
//            that issued it via the valid flags.
// Config   : MEMARB_RR_EN -- when defined, round-robin arbitration replaces
//            fixed load/store priority and the starvation guard is removed.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  // State records which kind of access was issued in the previous cycle,
  // i.e. who owns the data currently on mem_dout.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IF   = 2'd1,
    S_DR   = 2'd2,
    S_DW   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   if_win;
  logic   d_win;

`ifdef MEMARB_RR_EN
  // 1 = fetch won the most recent grant, 0 = load/store did.
  logic last_if_q;
  logic last_if_d;

  // Round-robin choice: on a tie the side that did not win last time wins.
  always_comb begin
    if_win    = 1'b0;
    d_win     = 1'b0;
    last_if_d = last_if_q;
    if (!reset) begin
      if_win = if_req && (!d_req || !last_if_q);
      d_win  = d_req && !if_win;
    end
    if (if_win) begin
      last_if_d = 1'b1;
    end else if (d_win) begin
      last_if_d = 1'b0;
    end
  end

  // Remember the most recent winner; fetch is treated as last winner after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_if_q <= 1'b1;
    end else begin
      last_if_q <= last_if_d;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Consecutive cycles fetch has been asking without being served.
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Fixed priority to load/store, overridden once fetch has waited long enough.
  always_comb begin
    if_win   = 1'b0;
    d_win    = 1'b0;
    starve_d = 4'd0;
    if (!reset) begin
      if_win = if_req && (!d_req || (starve_q == STARVE_LIM));
      d_win  = d_req && !if_win;
    end
    if (if_req && !if_win) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Next state follows this cycle's grant from any state.
  always_comb begin
    state_d = S_IDLE;
    if (if_win) begin
      state_d = S_IF;
    end else if (d_win) begin
      state_d = d_we ? S_DW : S_DR;
    end
  end

  // Access-tracking FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory port mux: idle cycles drive all zeros so no stray write can occur.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (if_win) begin
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_addr = d_addr;
      mem_din  = d_wdata;
      mem_we   = d_we;
    end
  end

  assign if_gnt = if_win;
  assign d_gnt  = d_win;

  // Valids are suppressed while reset is asserted so a read issued just
  // before reset never reports data.
  assign if_valid = !reset && (state_q == S_IF);
  assign d_valid  = !reset && (state_q == S_DR);

  assign if_rdata = mem_dout;
  assign d_rdata  = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven bench for mem_port_arbiter with a
//            behavioural write-first single-port memory attached.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic        pl_en;
  logic [9:0]  pl_a;
  logic [15:0] pl_d;
  logic [15:0] mem [0:1023];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  // Write-first single-port memory with registered read; preload port for setup.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_din;
      mem_dout <= mem_we ? mem_din : mem[mem_addr[9:0]];
    end
  end

  typedef struct {
    logic        rst;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        e_ig;
    logic        e_dg;
    logic        e_we;
    logic [15:0] e_a;
    logic [15:0] e_d;
    logic        e_iv;
    logic        e_dv;
    logic        e_chk;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic ir, input logic [15:0] ia,
    input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
    input logic eig, input logic edg, input logic ewe,
    input logic [15:0] ea, input logic [15:0] ed,
    input logic eiv, input logic edv, input logic ec, input logic [15:0] erd);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_ig = eig; v.e_dg = edg; v.e_we = ewe; v.e_a = ea; v.e_d = ed;
    v.e_iv = eiv; v.e_dv = edv; v.e_chk = ec; v.e_rd = erd;
    return v;
  endfunction

  // Drive one cycle of inputs, check mid-cycle, then advance past the next posedge.
  task automatic apply(input vec_t v, input int idx);
    logic ok;
    reset = v.rst; if_req = v.ir; if_addr = v.ia;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
    @(negedge clk);
    ok = (if_gnt === v.e_ig) && (d_gnt === v.e_dg) && (mem_we === v.e_we) &&
         (mem_addr === v.e_a) && (mem_din === v.e_d) &&
         (if_valid === v.e_iv) && (d_valid === v.e_dv);
    if (v.e_chk) ok = ok && (if_rdata === v.e_rd) && (d_rdata === v.e_rd);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got ig=%b dg=%b we=%b a=%h d=%h iv=%b dv=%b ird=%h drd=%h ; want ig=%b dg=%b we=%b a=%h d=%h iv=%b dv=%b rd=%h(chk=%b)",
               idx, if_gnt, d_gnt, mem_we, mem_addr, mem_din, if_valid, d_valid, if_rdata, d_rdata,
               v.e_ig, v.e_dg, v.e_we, v.e_a, v.e_d, v.e_iv, v.e_dv, v.e_rd, v.e_chk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pl_en = 1'b1; pl_a = '0; pl_d = '0;

    // Preload memory contents while the DUT is held in reset.
    @(negedge clk); pl_a = 10'h000; pl_d = 16'h1111;
    @(negedge clk); pl_a = 10'h020; pl_d = 16'h2020;
    @(negedge clk); pl_a = 10'h030; pl_d = 16'h3030;
    @(negedge clk); pl_a = 10'h3FE; pl_d = 16'hABCD;
    @(negedge clk); pl_en = 1'b0;
    @(posedge clk); #1;

    //               rst ir ia       dr dw da       dd        ig dg we a        d        iv dv ck rd
    // Reset held with both requests pending.
    tbl.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    // Store then fetch of the same address.
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h000A, 16'h4321, 0, 1, 1, 16'h000A, 16'h4321, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h000A, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h000A, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h4321));
    // Conflict: load wins, fetch follows.
    tbl.push_back(mk(0, 1, 16'h0000, 1, 0, 16'h03FE, 16'h0000, 0, 1, 0, 16'h03FE, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hABCD));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h1111));
    // Both requests held continuously.
`ifdef MEMARB_RR_EN
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 1, 0, 1, 16'h2020));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 1, 0, 1, 16'h2020));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h2020));
`else
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 0, 1, 1, 16'h3030));
    tbl.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030, 16'h0000, 1, 0, 1, 16'h2020));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h3030));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset arriving the cycle after a load grant, with a store pending during reset.
    apply(mk(0, 0, 16'h0000, 1, 0, 16'h03FE, 16'h0000, 0, 1, 0, 16'h03FE, 16'h0000, 0, 0, 0, 16'h0000), 100);
    apply(mk(1, 0, 16'h0000, 1, 1, 16'h03FE, 16'h5555, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000), 101);
    apply(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000), 102);
    apply(mk(0, 0, 16'h0000, 1, 0, 16'h03FE, 16'h0000, 0, 1, 0, 16'h03FE, 16'h0000, 0, 0, 0, 16'h0000), 103);
    apply(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hABCD), 104);

    // Back-to-back store then load of the same address returns the new data.
    apply(mk(0, 0, 16'h0000, 1, 1, 16'h0040, 16'h7777, 0, 1, 1, 16'h0040, 16'h7777, 0, 0, 0, 16'h0000), 200);
    apply(mk(0, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000), 201);
    apply(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h7777), 202);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
